fg_config_loader: RTL and testbench

- Byte-wide configuration front end for the function generator. Collects eight 8-bit writes into a 64-bit staging register and commits them atomically to the live configuration bus that drives the generator.
- Commit is either immediate or deferred to the next output-valid strobe, i.e. a sample boundary, so no sample is produced from a half-updated configuration.
- Sits between the host/register interface and the generator's configuration and enable inputs.

---
 rtl/fg_config_loader.sv | 113 +++++++++++
 tb/tb_fg_config_loader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fg_config_loader.sv
// Byte-wide configuration front end: stages eight bytes and commits them atomically
// to the live bus, either immediately or on the next sample boundary (or a timeout).
module fg_config_loader #(
  parameter int unsigned                    CONFIG_REG_BITWIDTH = 64,
  parameter logic [CONFIG_REG_BITWIDTH-1:0] RESET_CONFIG        = 64'h0,
  parameter int unsigned                    TIMEOUT_BITWIDTH    = 16,
  parameter logic [TIMEOUT_BITWIDTH-1:0]    TIMEOUT_CYCLES      = 16'hFFFF
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic [7:0]                     wrData_i,
  input  logic [2:0]                     wrAddr_i,
  input  logic                           wrValid_i,
  output logic                           wrReady_o,
  input  logic                           commit_i,
  input  logic                           commitMode_i,
  input  logic                           syncStrobe_i,
  input  logic                           enable_i,
  output logic [CONFIG_REG_BITWIDTH-1:0] CR_bus_o,
  output logic                           outputEnable_o,
  output logic                           busy_o,
  output logic                           commitDone_o,
  output logic                           timeout_o
);
  localparam int unsigned NUM_BYTES = CONFIG_REG_BITWIDTH / 8;

  typedef enum logic [1:0] {ST_IDLE, ST_PENDING, ST_APPLY} state_e;

  state_e                         state_q;
  logic [7:0]                     staging_q [NUM_BYTES];
  logic [CONFIG_REG_BITWIDTH-1:0] staging_flat;
  logic [CONFIG_REG_BITWIDTH-1:0] cr_q;
  logic [NUM_BYTES-1:0]           dirty_q;
  logic [TIMEOUT_BITWIDTH-1:0]    timer_q;
  logic                           oe_q;
  logic                           done_q;
  logic                           timeout_q;
  logic                           wr_fire;
  logic                           commit_go;

  assign wrReady_o = (state_q == ST_IDLE);
  assign wr_fire   = wrValid_i && wrReady_o;
  // A write landing in the same cycle as the commit counts as dirty data.
  assign commit_go = commit_i && ((dirty_q != '0) || wr_fire);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BYTES; gi++) begin : g_pack
      assign staging_flat[8*gi +: 8] = staging_q[gi];
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      for (int i = 0; i < NUM_BYTES; i++) begin
        staging_q[i] <= RESET_CONFIG[8*i +: 8];
      end
      cr_q      <= RESET_CONFIG;
      dirty_q   <= '0;
      timer_q   <= '0;
      oe_q      <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      oe_q   <= enable_i;
      if (wr_fire) begin
        staging_q[wrAddr_i] <= wrData_i;
        dirty_q[wrAddr_i]   <= 1'b1;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (commit_go) begin
            timeout_q <= 1'b0;
            // Nothing to synchronise against when the generator is not running.
            if (!commitMode_i || !oe_q) begin
              state_q <= ST_APPLY;
            end else begin
              state_q <= ST_PENDING;
              timer_q <= '0;
            end
          end
        end
        ST_PENDING: begin
          if (!oe_q || syncStrobe_i) begin
            state_q <= ST_APPLY;
          end else if (timer_q == TIMEOUT_CYCLES - 1'b1) begin
            state_q   <= ST_APPLY;
            timeout_q <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        ST_APPLY: begin
          cr_q    <= staging_flat;
          dirty_q <= '0;
          done_q  <= 1'b1;
          // Drop enable for one cycle so the generator restarts on the new word.
          oe_q    <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign CR_bus_o       = cr_q;
  assign outputEnable_o = oe_q;
  assign busy_o         = (state_q != ST_IDLE);
  assign commitDone_o   = done_q;
  assign timeout_o      = timeout_q;
endmodule

// File: tb/tb_fg_config_loader.sv
// Bench for fg_config_loader: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a behavioural model.
module tb_fg_config_loader;
  localparam int TO = 32;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  wrData = '0;
  logic [2:0]  wrAddr = '0;
  logic        wrValid = 1'b0;
  logic        wrReady;
  logic        commit = 1'b0;
  logic        mode = 1'b0;
  logic        strobe = 1'b0;
  logic        enable = 1'b0;
  logic [63:0] cr_bus;
  logic        oe, busy, done, tmo;

  int n_assert = 0;
  int n_fail = 0;

  fg_config_loader #(
    .CONFIG_REG_BITWIDTH(64),
    .RESET_CONFIG(64'h0),
    .TIMEOUT_BITWIDTH(16),
    .TIMEOUT_CYCLES(16'(TO))
  ) dut (
    .clk_i(clk), .rstn_i(rstn),
    .wrData_i(wrData), .wrAddr_i(wrAddr), .wrValid_i(wrValid), .wrReady_o(wrReady),
    .commit_i(commit), .commitMode_i(mode), .syncStrobe_i(strobe), .enable_i(enable),
    .CR_bus_o(cr_bus), .outputEnable_o(oe), .busy_o(busy),
    .commitDone_o(done), .timeout_o(tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: staged bytes, live word, and at most one commit in flight
  // that either lands on the next edge or waits with a remaining cycle budget.
  logic [7:0]  m_stg [8] = '{default: 8'h00};
  logic [7:0]  m_dirty = '0;
  logic [63:0] m_cr = '0;
  bit          m_oe = 0, m_done = 0, m_to = 0;
  bit          m_landing = 0, m_waiting = 0;
  int          m_budget = 0;

  function automatic logic [63:0] m_word();
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = m_stg[i];
    return w;
  endfunction

  always @(posedge clk) begin
    bit          accepting;
    bit          running;
    logic [7:0]  had_dirty;
    if (!rstn) begin
      for (int i = 0; i < 8; i++) m_stg[i] = 8'h00;
      m_dirty = '0; m_cr = '0; m_oe = 0; m_done = 0; m_to = 0;
      m_landing = 0; m_waiting = 0; m_budget = 0;
    end else begin
      accepting = !m_landing && !m_waiting;
      running   = m_oe;
      had_dirty = m_dirty;
      m_done    = 0;
      m_oe      = enable;
      if (m_landing) begin
        m_cr = m_word();
        m_dirty = '0;
        m_done = 1;
        m_oe = 0;
        m_landing = 0;
      end else if (m_waiting) begin
        m_budget--;
        if (!running || strobe) begin
          m_waiting = 0; m_landing = 1;
        end else if (m_budget == 0) begin
          m_waiting = 0; m_landing = 1; m_to = 1;
        end
      end else if (accepting) begin
        if (wrValid) begin
          m_stg[wrAddr] = wrData;
          m_dirty[wrAddr] = 1'b1;
        end
        if (commit && (had_dirty != 0 || wrValid)) begin
          m_to = 0;
          if (!mode || !running) m_landing = 1;
          else begin m_waiting = 1; m_budget = TO; end
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("cr_bus", cr_bus, m_cr);
    chk("wr_ready", wrReady, !(m_landing || m_waiting));
    chk("busy", busy, m_landing || m_waiting);
    chk("output_enable", oe, m_oe);
    chk("commit_done", done, m_done);
    chk("timeout", tmo, m_to);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    wrValid = 1'b1; wrAddr = a; wrData = d;
    cyc(1);
    wrValid = 1'b0;
  endtask

  initial begin
    int n;
    cyc(2);
    rstn = 1'b1;
    cyc(1);
    chk("rst_cr", cr_bus, 64'h0);
    chk("rst_oe", oe, 1'b0);
    chk("rst_ready", wrReady, 1'b1);
    chk("rst_timeout", tmo, 1'b0);

    // Full word, immediate commit
    enable = 1'b1;
    for (int i = 0; i < 8; i++) wr(3'(i), 8'(8'h10 + i));
    commit = 1'b1; mode = 1'b0;
    cyc(1);
    commit = 1'b0;
    chk("imm_busy", busy, 1'b1);
    chk("imm_cr_hold", cr_bus, 64'h0);
    chk("imm_oe_before", oe, 1'b1);
    cyc(1);
    chk("imm_cr", cr_bus, 64'h1716151413121110);
    chk("imm_done", done, 1'b1);
    chk("imm_oe_low", oe, 1'b0);
    cyc(1);
    chk("imm_done_once", done, 1'b0);
    chk("imm_oe_back", oe, 1'b1);

    // Synced commit, strobe 20 cycles later; held-off write during the wait
    wr(3'd1, 8'hAA);
    commit = 1'b1; mode = 1'b1;
    cyc(1);
    commit = 1'b0;
    wrValid = 1'b1; wrAddr = 3'd2; wrData = 8'h55;
    for (int i = 0; i < 20; i++) begin
      chk("sync_busy", busy, 1'b1);
      chk("sync_ready", wrReady, 1'b0);
      chk("sync_cr_hold", cr_bus, 64'h1716151413121110);
      cyc(1);
    end
    wrValid = 1'b0;
    strobe = 1'b1;
    cyc(1);
    strobe = 1'b0;
    chk("sync_cr_hold2", cr_bus, 64'h1716151413121110);
    cyc(1);
    chk("sync_cr", cr_bus, 64'h171615141312AA10);
    chk("sync_done", done, 1'b1);

    // Forced commit after the timeout budget
    cyc(1);
    wr(3'd3, 8'h33);
    commit = 1'b1; mode = 1'b1;
    cyc(1);
    commit = 1'b0;
    n = 0;
    while (cr_bus !== 64'h171615143312AA10 && n < 100) begin
      cyc(1);
      n++;
    end
    chk("timeout_latency", 64'(n), 64'(TO + 1));
    chk("timeout_set", tmo, 1'b1);
    cyc(1);
    wr(3'd4, 8'h44);
    commit = 1'b1; mode = 1'b1;
    cyc(1);
    commit = 1'b0;
    chk("timeout_cleared", tmo, 1'b0);
    chk("sync2_busy", busy, 1'b1);
    cyc(3);
    strobe = 1'b1;
    cyc(1);
    strobe = 1'b0;
    cyc(1);
    chk("sync2_cr", cr_bus, 64'h171615443312AA10);

    // Empty commit ignored; write+commit in the same cycle
    cyc(1);
    commit = 1'b1; mode = 1'b0;
    cyc(1);
    commit = 1'b0;
    chk("empty_busy", busy, 1'b0);
    cyc(1);
    chk("empty_done", done, 1'b0);
    wrValid = 1'b1; wrAddr = 3'd5; wrData = 8'h5A; commit = 1'b1; mode = 1'b0;
    cyc(1);
    wrValid = 1'b0; commit = 1'b0;
    chk("wc_busy", busy, 1'b1);
    cyc(1);
    chk("wc_cr", cr_bus, 64'h17165A443312AA10);

    // enable_i dropped while waiting for a strobe
    cyc(1);
    wr(3'd6, 8'h66);
    commit = 1'b1; mode = 1'b1;
    cyc(1);
    commit = 1'b0;
    cyc(2);
    enable = 1'b0;
    cyc(1);
    chk("drop_busy", busy, 1'b1);
    chk("drop_oe", oe, 1'b0);
    cyc(1);
    chk("drop_cr_hold", cr_bus, 64'h17165A443312AA10);
    cyc(1);
    chk("drop_cr", cr_bus, 64'h17665A443312AA10);
    chk("drop_done", done, 1'b1);

    // Asynchronous reset while pending discards everything
    enable = 1'b1;
    cyc(2);
    wr(3'd7, 8'h77);
    commit = 1'b1; mode = 1'b1;
    cyc(1);
    commit = 1'b0;
    cyc(2);
    rstn = 1'b0;
    #1;
    chk("arst_cr", cr_bus, 64'h0);
    chk("arst_busy", busy, 1'b0);
    cyc(1);
    rstn = 1'b1;
    cyc(1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      wrValid = ($urandom_range(0, 99) < 40);
      wrAddr  = 3'($urandom_range(0, 7));
      wrData  = 8'($urandom_range(0, 255));
      commit  = ($urandom_range(0, 99) < 15);
      mode    = 1'($urandom_range(0, 1));
      strobe  = ($urandom_range(0, 99) < 6);
      if ($urandom_range(0, 99) < 3) enable = ~enable;
      cyc(1);
    end
    wrValid = 1'b0; commit = 1'b0; strobe = 1'b0;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
